// File: rtl/pe_beat_sequencer.sv
// pe_beat_sequencer: steps the PE array through one vector instruction,
// beat by beat (READ -> EXEC -> WB), with tail byte enables on the last beat.
// Optional build macro: PE_SEQ_PERF_EN (stall cycle counter on perf_stall_cnt).

// Per-PE byte enable slice: byte k of this PE is on when its global index < nbytes.
module pe_be_lane #(
  parameter int LANE = 0,
  parameter int BCW  = 11
) (
  input  logic [BCW-1:0] nbytes,
  output logic [3:0]     be
);
  for (genvar k = 0; k < 4; k++) begin : g_byte
    localparam logic [BCW-1:0] IDX = BCW'(LANE * 4 + k);
    assign be[k] = (IDX < nbytes);
  end
endmodule

module pe_beat_sequencer #(
  parameter int NUM_PE = 4,
  parameter int VL_W   = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [3:0]            issue_op,
  input  logic [1:0]            issue_vsew,
  input  logic [VL_W-1:0]       issue_vl,
  input  logic [1:0]            issue_widening,
  input  logic [1:0]            issue_sat_mode,
  input  logic [1:0]            issue_out_mode,
  output logic                  rd_req,
  output logic [VL_W-1:0]       rd_beat,
  input  logic                  rd_valid,
  output logic                  pe_en,
  output logic [3:0]            pe_op,
  output logic [1:0]            pe_vsew,
  output logic [1:0]            pe_widening,
  output logic [1:0]            pe_sat_mode,
  output logic [1:0]            pe_out_mode,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [VL_W-1:0]       wb_beat,
  output logic [NUM_PE*4-1:0]   wb_byte_en,
  output logic                  wb_last,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           perf_stall_cnt
);

  // Byte-count arithmetic width: holds vl << 2 and vl + one beat of elements.
  localparam int BCW = VL_W + 3;
  localparam logic [BCW-1:0] BEAT_BYTES = BCW'(NUM_PE * 4);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] vsew;
    logic [1:0] widening;
    logic [1:0] sat_mode;
    logic [1:0] out_mode;
  } cfg_t;

  state_t            state, state_nx;
  cfg_t              cfg;
  logic [VL_W-1:0]   vl_q;
  logic [VL_W-1:0]   beat;
  logic [BCW-1:0]    base;      // elements consumed by earlier beats (beat * epb)
  logic              done_q;
  logic              accept;

  logic [2:0]        sew_sum;
  logic [1:0]        eff_sew;
  logic [BCW-1:0]    epb;
  logic [BCW-1:0]    rem;
  logic              is_last;
  logic [BCW-1:0]    nbytes;
  logic [NUM_PE-1:0][3:0] be_lane;

  assign accept  = (state == S_IDLE) && issue_valid;

  // Destination element width after widening, clamped to 32 bits.
  assign sew_sum = {1'b0, cfg.vsew} +
                   ((cfg.widening == 2'd1) ? 3'd1 : (cfg.widening == 2'd2) ? 3'd2 : 3'd0);
  assign eff_sew = (sew_sum > 3'd2) ? 2'd2 : sew_sum[1:0];
  assign epb     = BEAT_BYTES >> eff_sew;

  // Remaining elements are always > 0 inside an instruction; last when they fit one beat.
  assign rem     = BCW'(vl_q) - base;
  assign is_last = (rem <= epb);
  assign nbytes  = is_last ? (rem << eff_sew) : BEAT_BYTES;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    pe_be_lane #(.LANE(g), .BCW(BCW)) u_lane (
      .nbytes (nbytes),
      .be     (be_lane[g])
    );
  end

  // State, config latch, beat tracking and completion pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      cfg    <= '0;
      vl_q   <= '0;
      beat   <= '0;
      base   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (accept && (issue_vl == '0)) ||
                ((state == S_WB) && wb_ready && is_last);
      if (accept) begin
        cfg  <= '{op: issue_op, vsew: issue_vsew, widening: issue_widening,
                  sat_mode: issue_sat_mode, out_mode: issue_out_mode};
        vl_q <= issue_vl;
        beat <= '0;
        base <= '0;
      end else if ((state == S_WB) && wb_ready && !is_last) begin
        beat <= beat + 1'b1;
        base <= base + epb;
      end
    end
  end

  // Next state and per-state output decode.
  always_comb begin
    state_nx    = state;
    issue_ready = 1'b0;
    rd_req      = 1'b0;
    rd_beat     = '0;
    pe_en       = 1'b0;
    wb_valid    = 1'b0;
    wb_beat     = '0;
    wb_byte_en  = '0;
    wb_last     = 1'b0;
    unique case (state)
      S_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && (issue_vl != '0)) state_nx = S_READ;
      end
      S_READ: begin
        rd_req  = 1'b1;
        rd_beat = beat;
        if (rd_valid) state_nx = S_EXEC;
      end
      S_EXEC: begin
        pe_en    = 1'b1;
        state_nx = S_WB;
      end
      S_WB: begin
        wb_valid   = 1'b1;
        wb_beat    = beat;
        wb_byte_en = be_lane;
        wb_last    = is_last;
        if (wb_ready) state_nx = is_last ? S_IDLE : S_READ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign pe_op       = cfg.op;
  assign pe_vsew     = cfg.vsew;
  assign pe_widening = cfg.widening;
  assign pe_sat_mode = cfg.sat_mode;
  assign pe_out_mode = cfg.out_mode;

`ifdef PE_SEQ_PERF_EN
  // Saturating count of cycles stalled on operand read or writeback.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      perf_stall_cnt <= '0;
    end else if (((state == S_READ) && !rd_valid) || ((state == S_WB) && !wb_ready)) begin
      if (perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_beat_sequencer.sv
// Directed bench for pe_beat_sequencer (NUM_PE=4, VL_W=8).
module tb_pe_beat_sequencer;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_op = '0;
  logic [1:0]  issue_vsew = '0;
  logic [7:0]  issue_vl = '0;
  logic [1:0]  issue_widening = '0;
  logic [1:0]  issue_sat_mode = '0;
  logic [1:0]  issue_out_mode = '0;
  logic        rd_req;
  logic [7:0]  rd_beat;
  logic        rd_valid = 1'b1;
  logic        pe_en;
  logic [3:0]  pe_op;
  logic [1:0]  pe_vsew, pe_widening, pe_sat_mode, pe_out_mode;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [7:0]  wb_beat;
  logic [15:0] wb_byte_en;
  logic        wb_last;
  logic        busy;
  logic        done;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pe_beat_sequencer #(.NUM_PE(4), .VL_W(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vsew(issue_vsew), .issue_vl(issue_vl), .issue_widening(issue_widening),
    .issue_sat_mode(issue_sat_mode), .issue_out_mode(issue_out_mode),
    .rd_req(rd_req), .rd_beat(rd_beat), .rd_valid(rd_valid),
    .pe_en(pe_en), .pe_op(pe_op), .pe_vsew(pe_vsew), .pe_widening(pe_widening),
    .pe_sat_mode(pe_sat_mode), .pe_out_mode(pe_out_mode),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_beat(wb_beat),
    .wb_byte_en(wb_byte_en), .wb_last(wb_last),
    .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer an instruction in IDLE; it is taken at the next edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] vsew, input logic [7:0] vl,
                       input logic [1:0] wid, input logic [1:0] sat, input logic [1:0] om,
                       input bit hold);
    issue_op = op; issue_vsew = vsew; issue_vl = vl;
    issue_widening = wid; issue_sat_mode = sat; issue_out_mode = om;
    issue_valid = 1'b1;
    step();
    cyc = 1;
    if (!hold) issue_valid = 1'b0;
  endtask

  // Entered while observing READ; leaves after the WB handshake edge.
  task automatic run_beat(input int b, input logic [31:0] be, input logic last);
    chk($sformatf("rd_req_b%0d", b), 32'(rd_req), 1);
    chk($sformatf("rd_beat_b%0d", b), 32'(rd_beat), 32'(b));
    chk($sformatf("iss_rdy_busy_b%0d", b), 32'(issue_ready), 0);
    step();
    chk($sformatf("pe_en_b%0d", b), 32'({pe_en, rd_req, wb_valid}), 32'b100);
    step();
    chk($sformatf("wb_valid_b%0d", b), 32'({wb_valid, pe_en}), 32'b10);
    chk($sformatf("wb_beat_b%0d", b), 32'(wb_beat), 32'(b));
    chk($sformatf("wb_be_b%0d", b), 32'(wb_byte_en), be);
    chk($sformatf("wb_last_b%0d", b), 32'(wb_last), 32'(last));
    chk($sformatf("done_lo_b%0d", b), 32'(done), 0);
    step();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_ctl", 32'({busy, done, rd_req, pe_en, wb_valid, wb_last}), 0);
    chk("rst_cfg", 32'({pe_op, pe_vsew, pe_widening, pe_sat_mode, pe_out_mode}), 0);
    chk("rst_wb", 32'({wb_byte_en, wb_beat, rd_beat}), 0);
    chk("rst_perf", perf_stall_cnt, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    step();

    // vl=40, 8-bit: three beats, tail 8 bytes
    issue(4'd3, 2'd0, 8'd40, 2'd0, 2'd1, 2'd2, 1'b0);
    chk("t1_cfg", 32'({pe_op, pe_sat_mode, pe_out_mode}), 32'({4'd3, 2'd1, 2'd2}));
    run_beat(0, 32'hFFFF, 1'b0);
    run_beat(1, 32'hFFFF, 1'b0);
    chk("t1_lat_pre", 32'(cyc), 7);
    run_beat(2, 32'h00FF, 1'b1);
    chk("t1_lat_final_wb", 32'(cyc - 1), 9);
    chk("t1_done", 32'({done, issue_ready, busy}), 32'b110);
    step();
    chk("t1_done_pulse", 32'(done), 0);

    // vsew=16b widened: epb 4, tail 1 element = 4 bytes
    issue(4'd5, 2'd1, 8'd5, 2'd1, 2'd0, 2'd0, 1'b0);
    chk("t2_widening", 32'(pe_widening), 1);
    run_beat(0, 32'hFFFF, 1'b0);
    chk("t2_widening_mid", 32'(pe_widening), 1);
    run_beat(1, 32'h000F, 1'b1);
    chk("t2_done", 32'(done), 1);
    step();

    // vl=0: accepted, no activity, done next cycle
    issue(4'd7, 2'd0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    chk("t3_idle", 32'({rd_req, pe_en, wb_valid, busy}), 0);
    chk("t3_done", 32'({done, issue_ready}), 32'b11);
    chk("t3_cfg", 32'(pe_op), 7);
    step();
    chk("t3_done_pulse", 32'({done, rd_req, pe_en, wb_valid}), 0);

    // wb_ready low for 3 cycles on beat 0 (32-bit, vl=6: tail 2 elem = 8 bytes)
    issue(4'd1, 2'd2, 8'd6, 2'd0, 2'd0, 2'd0, 1'b0);
    step(); step();
    wb_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_hold_%0d", i), 32'({wb_valid, wb_last, wb_beat, wb_byte_en}),
          32'({1'b1, 1'b0, 8'd0, 16'hFFFF}));
      if (i < 3) step();
    end
    wb_ready = 1'b1;
    step();
    run_beat(1, 32'h00FF, 1'b1);
`ifdef PE_SEQ_PERF_EN
    chk("t4_perf", perf_stall_cnt, 3);
`else
    chk("t4_perf", perf_stall_cnt, 0);
`endif
    chk("t4_done", 32'(done), 1);
    step();

    // Second issue held during busy
    issue(4'd2, 2'd2, 8'd5, 2'd0, 2'd0, 2'd1, 1'b1);
    issue_op = 4'd9; issue_vl = 8'd4; issue_out_mode = 2'd3;
    run_beat(0, 32'hFFFF, 1'b0);
    chk("t5_cfg_held", 32'({pe_op, pe_out_mode}), 32'({4'd2, 2'd1}));
    run_beat(1, 32'h000F, 1'b1);
    chk("t5_done_ready", 32'({done, issue_ready}), 32'b11);
    chk("t5_cfg_old", 32'(pe_op), 2);
    step();
    issue_valid = 1'b0;
    chk("t5_cfg_new", 32'({pe_op, pe_out_mode}), 32'({4'd9, 2'd3}));
    run_beat(0, 32'hFFFF, 1'b1);
    chk("t5_done2", 32'(done), 1);
    step();

    // Reset during WB of beat 1
    issue(4'd4, 2'd0, 8'd40, 2'd0, 2'd2, 2'd1, 1'b0);
    run_beat(0, 32'hFFFF, 1'b0);
    step(); step();
    chk("t6_in_wb1", 32'({wb_valid, wb_beat}), 32'({1'b1, 8'd1}));
    n_reset = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(issue_ready), 1);
    chk("t6_rst_ctl", 32'({busy, done, rd_req, pe_en, wb_valid, wb_last, wb_byte_en, wb_beat}), 0);
    chk("t6_rst_cfg", 32'({pe_op, pe_sat_mode, pe_out_mode}), 0);
    step();
    n_reset = 1'b1;
    step();
    chk("t6_no_done", 32'({done, busy}), 0);
    chk("t6_rst_perf", perf_stall_cnt, 0);
    issue(4'd6, 2'd1, 8'd5, 2'd1, 2'd0, 2'd0, 1'b0);
    run_beat(0, 32'hFFFF, 1'b0);
    run_beat(1, 32'h000F, 1'b1);
    chk("t6_fresh_done", 32'({done, pe_op}), 32'({1'b1, 4'd6}));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
